// File: rtl/vdc_pkg.sv
// Shared types and constants for the VDC two-port register bus initiator.
package vdc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StPoll,
    StPcap,
    StData,
    StDcap,
    StResp
  } vdc_mst_state_t;

  localparam logic        VDC_RS_ADDR        = 1'b0;
  localparam logic        VDC_RS_DATA        = 1'b1;
  localparam int unsigned VDC_STAT_READY_BIT = 7;

endpackage

// File: rtl/vdc_cpu_master.sv
// VDC bus initiator: select register, poll status ready bit, then write or read the data port.
module vdc_cpu_master
  import vdc_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 1023,
  parameter bit          CACHE_SEL  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enableBus,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       cs,
  output logic       rs,
  output logic       we,
  output logic [7:0] db_out,
  input  logic [7:0] db_in,
  input  logic       invalidate
);

  vdc_mst_state_t r_state;
  vdc_mst_state_t w_state_d;

  logic        r_op_write;
  logic [7:0]  r_reg;
  logic [7:0]  r_data;
  logic [15:0] r_poll_cnt;
  logic [7:0]  r_cache_reg;
  logic        r_cache_vld;
  logic [7:0]  r_rsp_data;
  logic        r_rsp_err;

  logic w_hit;
  logic w_limit;
  logic w_stat_ready;

  assign w_hit        = CACHE_SEL && r_cache_vld && (req_reg == r_cache_reg);
  assign w_limit      = 32'(r_poll_cnt) >= POLL_LIMIT;
  assign w_stat_ready = db_in[VDC_STAT_READY_BIT];

  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

  always_comb begin
    w_state_d = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    cs        = 1'b0;
    rs        = 1'b0;
    we        = 1'b0;
    db_out    = 8'h00;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) w_state_d = w_hit ? StPoll : StSel;
      end
      StSel: begin
        cs     = enableBus;
        rs     = VDC_RS_ADDR;
        we     = 1'b1;
        db_out = r_reg;
        if (enableBus) w_state_d = StPoll;
      end
      StPoll: begin
        cs = enableBus;
        rs = VDC_RS_ADDR;
        if (enableBus) w_state_d = StPcap;
      end
      StPcap: begin
        if (w_stat_ready)  w_state_d = StData;
        else if (w_limit)  w_state_d = StResp;
        else               w_state_d = StPoll;
      end
      StData: begin
        cs     = enableBus;
        rs     = VDC_RS_DATA;
        we     = r_op_write;
        db_out = r_data;
        if (enableBus) w_state_d = r_op_write ? StResp : StDcap;
      end
      StDcap: w_state_d = StResp;
      StResp: begin
        rsp_valid = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // Reset pulls the bus and handshakes low in the same cycle, before the edge that applies it.
    if (reset) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      cs        = 1'b0;
      rs        = 1'b0;
      we        = 1'b0;
      db_out    = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_op_write  <= 1'b0;
      r_reg       <= 8'h00;
      r_data      <= 8'h00;
      r_poll_cnt  <= 16'h0000;
      r_cache_reg <= 8'h00;
      r_cache_vld <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_op_write <= req_write;
            r_reg      <= req_reg;
            r_data     <= req_data;
            r_poll_cnt <= 16'h0000;
          end
        end
        StSel: begin
          if (enableBus) begin
            r_cache_reg <= r_reg;
            r_cache_vld <= 1'b1;
          end
        end
        StPoll: begin
          if (enableBus && (r_poll_cnt != 16'hFFFF)) r_poll_cnt <= r_poll_cnt + 16'd1;
        end
        StPcap: begin
          if (!w_stat_ready && w_limit) r_rsp_err <= 1'b1;
        end
        StData: begin
          if (enableBus) r_rsp_err <= 1'b0;
        end
        StDcap: r_rsp_data <= db_in;
        default: ;
      endcase
      // Placed after the SEL commit so a coincident invalidate wins.
      if (invalidate) r_cache_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vdc_cpu_master.sv
// Scoreboard bench for vdc_cpu_master with a behavioural VDC status/data responder.
module tb_vdc_cpu_master;

  logic       clk;
  logic       reset;
  logic       enableBus;
  logic       req_valid, req_valid_l;
  logic       req_write;
  logic [7:0] req_reg, req_data;
  logic       invalidate;
  logic [7:0] db_in, db_in_l;

  logic       req_ready, rsp_valid, rsp_err, cs, rs, we;
  logic [7:0] rsp_data, db_out;
  logic       req_ready_l, rsp_valid_l, rsp_err_l, cs_l, rs_l, we_l;
  logic [7:0] rsp_data_l, db_out_l;

  int n_checks = 0;
  int n_errors = 0;

  // VDC model state
  int         eb_cnt = 0;
  bit         eb_const = 1'b0;
  int         stat_idx = 0;
  int         ready_after = 0;
  logic [7:0] rd_val = 8'h00;
  logic [7:0] pend_val = 8'h00;
  bit         pend = 1'b0;

  logic [9:0] acc_q[$], acc_q_l[$], exp_acc[$], exp_acc_l[$];
  logic [8:0] rsp_q[$], rsp_q_l[$], exp_rsp[$], exp_rsp_l[$];

  vdc_cpu_master dut (
    .clk(clk), .reset(reset), .enableBus(enableBus),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_reg(req_reg), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cs(cs), .rs(rs), .we(we), .db_out(db_out), .db_in(db_in), .invalidate(invalidate)
  );

  vdc_cpu_master #(.POLL_LIMIT(3), .CACHE_SEL(1'b1)) dut_lim (
    .clk(clk), .reset(reset), .enableBus(enableBus),
    .req_valid(req_valid_l), .req_ready(req_ready_l), .req_write(req_write),
    .req_reg(req_reg), .req_data(req_data),
    .rsp_valid(rsp_valid_l), .rsp_data(rsp_data_l), .rsp_err(rsp_err_l),
    .cs(cs_l), .rs(rs_l), .we(we_l), .db_out(db_out_l), .db_in(db_in_l),
    .invalidate(invalidate)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #2;
    if (eb_const) begin
      enableBus = 1'b1;
    end else begin
      eb_cnt    = (eb_cnt + 1) % 4;
      enableBus = (eb_cnt == 0);
    end
  end

  // Bus monitor and VDC responder; read data appears on db_in after the access edge.
  always @(negedge clk) begin
    if (cs) begin
      acc_q.push_back({rs, we, db_out});
      if (!we) begin
        pend_val = rs ? rd_val : ((stat_idx >= ready_after) ? 8'h80 : 8'h00);
        if (!rs) stat_idx++;
        pend = 1'b1;
      end
    end
    if (cs_l) acc_q_l.push_back({rs_l, we_l, db_out_l});
    if (rsp_valid) rsp_q.push_back({rsp_err, rsp_data});
    if (rsp_valid_l) rsp_q_l.push_back({rsp_err_l, rsp_data_l});
  end

  always @(posedge clk) begin
    #1;
    if (pend) begin
      db_in = pend_val;
      pend  = 1'b0;
    end
  end

  task automatic run_req(input bit lim, input logic w, input logic [7:0] r, input logic [7:0] d,
                         output bit done);
    @(posedge clk);
    #2;
    req_write = w;
    req_reg   = r;
    req_data  = d;
    stat_idx  = 0;
    if (lim) req_valid_l = 1'b1;
    else     req_valid   = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((lim ? req_ready_l : req_ready) === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #2;
    req_valid   = 1'b0;
    req_valid_l = 1'b0;
    if (done) begin
      done = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if ((lim ? rsp_valid_l : rsp_valid) === 1'b1) begin
          done = 1'b1;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    eb_const = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_req_ready: got %b exp 0", req_ready);
    end
    n_checks++;
    if (cs !== 1'b0 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_cs_rsp: got cs=%b rsp_valid=%b exp 0/0", cs, rsp_valid);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    eb_const = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || req_ready_l !== 1'b1) begin
      n_errors++; $display("FAIL idle_ready: got %b/%b exp 1/1", req_ready, req_ready_l);
    end
    n_checks++;
    if (rsp_data !== 8'h00 || rsp_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_rsp: got data=%h err=%b exp 00/0", rsp_data, rsp_err);
    end
    n_checks++;
    if ({cs, rs, we, db_out} !== 11'h000) begin
      n_errors++; $display("FAIL reset_bus: got %h exp 000", {cs, rs, we, db_out});
    end
  endtask

  task automatic compare_main(input string name);
    logic [9:0] e, a;
    logic [8:0] er, ar;
    while (exp_acc.size() > 0) begin
      e = exp_acc.pop_front();
      n_checks++;
      if (acc_q.size() == 0) begin
        n_errors++; $display("FAIL %s_acc: got none exp %h", name, e);
      end else begin
        a = acc_q.pop_front();
        if (a !== e) begin n_errors++; $display("FAIL %s_acc: got %h exp %h", name, a, e); end
      end
    end
    n_checks++;
    if (acc_q.size() != 0) begin
      n_errors++; $display("FAIL %s_extra_acc: got %0d extra exp 0", name, acc_q.size());
      acc_q.delete();
    end
    while (exp_rsp.size() > 0) begin
      er = exp_rsp.pop_front();
      n_checks++;
      if (rsp_q.size() == 0) begin
        n_errors++; $display("FAIL %s_rsp: got none exp %h", name, er);
      end else begin
        ar = rsp_q.pop_front();
        if (ar !== er) begin n_errors++; $display("FAIL %s_rsp: got %h exp %h", name, ar, er); end
      end
    end
    n_checks++;
    if (rsp_q.size() != 0) begin
      n_errors++; $display("FAIL %s_extra_rsp: got %0d extra exp 0", name, rsp_q.size());
      rsp_q.delete();
    end
  endtask

  task automatic check_done(input string name, input bit done);
    n_checks++;
    if (!done) begin n_errors++; $display("FAIL %s_timeout: got no response exp rsp_valid", name); end
  endtask

  task automatic test_write_uncached();
    bit done;
    ready_after = 0;
    exp_acc.push_back({1'b0, 1'b1, 8'h1A});
    exp_acc.push_back({1'b0, 1'b0, 8'h00});
    exp_acc.push_back({1'b1, 1'b1, 8'hF0});
    exp_rsp.push_back({1'b0, 8'h00});
    run_req(1'b0, 1'b1, 8'd26, 8'hF0, done);
    check_done("write_uncached", done);
    compare_main("write_uncached");
  endtask

  task automatic test_read_cache();
    bit done;
    ready_after = 0;
    rd_val      = 8'h55;
    exp_acc.push_back({1'b0, 1'b1, 8'h0C});
    exp_acc.push_back({1'b0, 1'b0, 8'h00});
    exp_acc.push_back({1'b1, 1'b0, 8'h00});
    exp_rsp.push_back({1'b0, 8'h55});
    run_req(1'b0, 1'b0, 8'd12, 8'h00, done);
    check_done("read_first", done);
    exp_acc.push_back({1'b0, 1'b0, 8'h00});
    exp_acc.push_back({1'b1, 1'b0, 8'h00});
    exp_rsp.push_back({1'b0, 8'h55});
    run_req(1'b0, 1'b0, 8'd12, 8'h00, done);
    check_done("read_cached", done);
    compare_main("read_cache");
  endtask

  task automatic test_poll();
    bit done;
    ready_after = 5;
    for (int i = 0; i < 6; i++) exp_acc.push_back({1'b0, 1'b0, 8'h00});
    exp_acc.push_back({1'b1, 1'b1, 8'h3C});
    // A write leaves the last read data in place.
    exp_rsp.push_back({1'b0, 8'h55});
    run_req(1'b0, 1'b1, 8'd12, 8'h3C, done);
    check_done("poll", done);
    compare_main("poll");
  endtask

  task automatic test_timeout();
    bit done;
    logic [9:0] e, a;
    logic [8:0] ar;
    exp_acc_l.push_back({1'b0, 1'b1, 8'h05});
    for (int i = 0; i < 3; i++) exp_acc_l.push_back({1'b0, 1'b0, 8'h00});
    exp_rsp_l.push_back({1'b1, 8'h00});
    run_req(1'b1, 1'b0, 8'd5, 8'h00, done);
    check_done("timeout", done);
    while (exp_acc_l.size() > 0) begin
      e = exp_acc_l.pop_front();
      n_checks++;
      if (acc_q_l.size() == 0) begin
        n_errors++; $display("FAIL timeout_acc: got none exp %h", e);
      end else begin
        a = acc_q_l.pop_front();
        if (a !== e) begin n_errors++; $display("FAIL timeout_acc: got %h exp %h", a, e); end
      end
    end
    n_checks++;
    if (acc_q_l.size() != 0) begin
      n_errors++; $display("FAIL timeout_extra_acc: got %0d extra exp 0", acc_q_l.size());
    end
    n_checks++;
    if (rsp_q_l.size() != 1) begin
      n_errors++; $display("FAIL timeout_rsp_count: got %0d exp 1", rsp_q_l.size());
    end else begin
      ar = rsp_q_l.pop_front();
      n_checks++;
      if (ar !== exp_rsp_l.pop_front()) begin
        n_errors++; $display("FAIL timeout_rsp: got %h exp 100", ar);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    bit seen;
    ready_after = 1000;
    eb_const    = 1'b1;
    @(posedge clk);
    #2;
    req_write = 1'b1;
    req_reg   = 8'd12;
    req_data  = 8'h99;
    stat_idx  = 0;
    req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs === 1'b1 && rs === 1'b0 && we === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL reset_mid_poll: got no status read exp one"); end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cs !== 1'b0) begin n_errors++; $display("FAIL reset_mid_cs: got %b exp 0", cs); end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    eb_const = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_mid_ready: got %b exp 1", req_ready); end
    n_checks++;
    if (rsp_q.size() != 0) begin
      n_errors++; $display("FAIL reset_mid_rsp: got %0d responses exp 0", rsp_q.size());
      rsp_q.delete();
    end
    acc_q.delete();
    ready_after = 0;
    exp_acc.push_back({1'b0, 1'b1, 8'h0C});
    exp_acc.push_back({1'b0, 1'b0, 8'h00});
    exp_acc.push_back({1'b1, 1'b1, 8'h99});
    exp_rsp.push_back({1'b0, 8'h00});
    run_req(1'b0, 1'b1, 8'd12, 8'h99, done);
    check_done("reset_mid_req", done);
    compare_main("reset_mid");
  endtask

  task automatic test_invalidate();
    bit done;
    ready_after = 0;
    exp_acc.push_back({1'b0, 1'b1, 8'h1A});
    exp_acc.push_back({1'b0, 1'b0, 8'h00});
    exp_acc.push_back({1'b1, 1'b1, 8'h11});
    exp_acc.push_back({1'b0, 1'b0, 8'h00});
    exp_acc.push_back({1'b1, 1'b1, 8'h22});
    exp_acc.push_back({1'b0, 1'b1, 8'h1A});
    exp_acc.push_back({1'b0, 1'b0, 8'h00});
    exp_acc.push_back({1'b1, 1'b1, 8'h33});
    for (int i = 0; i < 3; i++) exp_rsp.push_back({1'b0, 8'h00});
    run_req(1'b0, 1'b1, 8'd26, 8'h11, done);
    check_done("inv_first", done);
    run_req(1'b0, 1'b1, 8'd26, 8'h22, done);
    check_done("inv_cached", done);
    @(posedge clk);
    #2;
    invalidate = 1'b1;
    @(posedge clk);
    #2;
    invalidate = 1'b0;
    run_req(1'b0, 1'b1, 8'd26, 8'h33, done);
    check_done("inv_after", done);
    compare_main("invalidate");
  endtask

  initial begin
    reset       = 1'b1;
    enableBus   = 1'b0;
    req_valid   = 1'b0;
    req_valid_l = 1'b0;
    req_write   = 1'b0;
    req_reg     = 8'h00;
    req_data    = 8'h00;
    invalidate  = 1'b0;
    db_in       = 8'h00;
    db_in_l     = 8'h00;
    test_reset();
    test_write_uncached();
    test_read_cache();
    test_poll();
    test_timeout();
    test_reset_mid();
    test_invalidate();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion exp finish within time limit");
    $fatal(1);
  end

endmodule
